dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. It sits directly downstream of the single-cycle core's data port. It consumes the core's address, read/write enables and write data, and returns read data plus a stall that freezes the PC. Misses and all writes go to main data memory over a word-wide req/ack handshake.

Parameters:
ADDR_W, 12, core byte-address width; word address = addr[ADDR_W-1:2]
LINES, 32, number of cache lines (power of 2)
WPL, 4, words per line (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_addr  in  ADDR_W  byte address from core; bits [1:0] ignored
cpu_re  in  1  load request
cpu_we  in  1  store request (full word; core pre-masks sb/sh data)
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data; valid when cpu_re=1 and stall=0
stall  out  1  combinational; core holds PC and request while high
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write beat, 0 = read beat
mem_addr  out  ADDR_W-2  word address to memory
mem_wdata  out  32  write data to memory
mem_rdata  in  32  read data; valid with mem_ack
mem_ack  in  1  one-cycle beat completion

Behaviour:
- Address split (defaults): offset = addr[3:2], index = addr[8:4], tag = addr[11:9].
- Storage: valid[LINES], tag[LINES], data[LINES][WPL]. Reads are asynchronous; writes occur on clk.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, cpu_we=1:
  - stall=1; next state WRITE.
  - Register mem_we=1, mem_addr = word address, mem_wdata = cpu_wdata.
  - cpu_we has priority if cpu_re is also high.
- IDLE, cpu_re=1, hit (valid & tag match):
  - stall=0; cpu_rdata = data[index][offset] in the same cycle; no state change.
- IDLE, cpu_re=1, miss:
  - stall=1; next state REFILL; beat counter = 0.
  - mem_addr = {tag,index,0}; mem_we=0.
- REFILL:
  - mem_req=1, stall=1.
  - On each mem_ack: write mem_rdata to data[index][beat], increment beat, advance mem_addr.
  - On the ack of beat WPL-1: set valid[index], write tag, go to IDLE, deassert mem_req.
  - The next cycle is a hit and stall falls.
  - Read-miss latency = 1 + sum of beat latencies + 1 cycle.
- WRITE:
  - mem_req=1; stall = !mem_ack.
  - On mem_ack: if the address hits, update data[index][offset] with cpu_wdata; go to IDLE.
  - The core advances on that same edge.
  - A write miss does not allocate.
- cpu_rdata = 0 whenever no read hit is presented.
- mem_req drops in the cycle after the accepting ack. No back-to-back beat without a one-cycle gap is required.
- Reset, including mid-REFILL or mid-WRITE:
  - State to IDLE; all valid bits cleared; beat counter 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Data array contents are not cleared.
  - Memory must tolerate an abandoned request.
- Outputs after reset with no request: stall=0, cpu_rdata=0, all mem_* = 0.
- Inputs cpu_addr/re/we/wdata are held stable by the core while stall=1. Behaviour when they change during stall is undefined.

Decomposition:
- Shared package dcache_pkg holds:
  - the state enum {IDLE, REFILL, WRITE};
  - localparams OFF_W = log2(WPL), IDX_W = log2(LINES), TAG_W = ADDR_W-2-OFF_W-IDX_W;
  - field-extract helper functions.
- One sub-module, dcache_array: valid/tag/data storage with async read, clocked line/word write, and synchronous valid clear on reset.

Test Plan:
- Reset, then idle for 5 cycles -> stall=0, mem_req=0, cpu_rdata=0.
- Cold load from 0x040, memory returning 0x11,0x22,0x33,0x44 for words 0x010–0x013 with ack after 2 cycles each:
  - stall stays high through the 4 acks;
  - mem_addr steps 0x010..0x013;
  - stall falls the cycle after the last ack with cpu_rdata=0x11.
  - A load of 0x04C then hits at once with 0x44.
- Store 0xDEADBEEF to 0x044 (a hit):
  - mem_we=1, mem_addr=0x011; stall=1 until ack, low on the ack cycle.
  - A following load of 0x044 hits with 0xDEADBEEF and no mem_req.
- Store to 0x844 (miss, same index, different tag):
  - memory is written;
  - a load of 0x044 still hits with the old line;
  - a load of 0x844 misses and refills.
- Conflict: a load of 0x240 after 0x040 was cached -> refill evicts the line; a reload of 0x040 misses again.
- Assert reset during beat 2 of a refill:
  - next cycle mem_req=0 and stall=0;
  - a re-issued load misses and performs a full 4-beat refill.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and address helpers for the data cache
// Default geometry: 12-bit byte address, 32 lines, 4 words per line.
// Field layout of a byte address: {tag, index, offset, 2'b00}.
package dcache_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_LINES  = 32;
  localparam int DEF_WPL    = 4;

  localparam int OFF_W = $clog2(DEF_WPL);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = DEF_ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  // Extract 'width' bits starting at bit 'lsb'; a width of 32 yields the whole word.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  // Byte address to word address.
  function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - word-wide req/ack memory bus between cache controller and data memory
// mem_req   : controller -> memory, held until mem_ack
// mem_we    : controller -> memory, 1 = write beat
// mem_addr  : controller -> memory, word address
// mem_wdata : controller -> memory, write data
// mem_rdata : memory -> controller, valid with mem_ack
// mem_ack   : memory -> controller, one-cycle beat completion
interface dcache_if #(
  parameter int ADDR_W = dcache_pkg::DEF_ADDR_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/tag/data storage for a direct-mapped cache
// clk, reset      : clock, synchronous active-high reset (clears valid bits only)
// index           : line selected for both read and write
// rd_offset       : word selected for the asynchronous read
// rd_valid/tag/data : asynchronous read of the selected line/word
// word_we         : write wr_data into data[index][wr_offset] on clk
// line_set        : mark line valid and store wr_tag on clk
module dcache_array
  import dcache_pkg::*;
#(
  parameter int IDX_BITS = IDX_W,
  parameter int OFF_BITS = OFF_W,
  parameter int TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] index,
  input  logic [OFF_BITS-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [31:0]         rd_data,
  input  logic                word_we,
  input  logic [OFF_BITS-1:0] wr_offset,
  input  logic [31:0]         wr_data,
  input  logic                line_set,
  input  logic [TAG_BITS-1:0] wr_tag
);

  localparam int N_LINES = 1 << IDX_BITS;
  localparam int N_WORDS = 1 << OFF_BITS;

  logic [N_LINES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q  [N_LINES];
  logic [31:0]         data_q [N_LINES][N_WORDS];

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index][rd_offset];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (line_set) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tags and data are left untouched by reset; a cleared valid bit hides them.
  always_ff @(posedge clk) begin
    if (line_set && !reset) begin
      tag_q[index] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) begin
      data_q[index][wr_offset] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
// clk, reset : clock, synchronous active-high reset
// cpu_addr   : byte address from core (bits [1:0] ignored)
// cpu_re     : load request
// cpu_we     : store request (full word), wins over cpu_re
// cpu_wdata  : store data
// cpu_rdata  : load data, valid when cpu_re=1 and stall=0, else 0
// stall      : combinational, core holds PC and request while high
// mem        : memory bus (master side)
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINES  = DEF_LINES,
  parameter int WPL    = DEF_WPL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  dcache_if.master          mem
);

  localparam int OFF_BITS = $clog2(WPL);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_W - 2 - OFF_BITS - IDX_BITS;
  localparam int WA_W     = ADDR_W - 2;

  // Address fields of the current core request
  logic [WA_W-1:0]     word_addr;
  logic [OFF_BITS-1:0] offset;
  logic [IDX_BITS-1:0] index;
  logic [TAG_BITS-1:0] tag;

  assign word_addr = WA_W'(word_of(32'(cpu_addr)));
  assign offset    = OFF_BITS'(addr_field(32'(cpu_addr), 2, OFF_BITS));
  assign index     = IDX_BITS'(addr_field(32'(cpu_addr), 2 + OFF_BITS, IDX_BITS));
  assign tag       = TAG_BITS'(addr_field(32'(cpu_addr), 2 + OFF_BITS + IDX_BITS, TAG_BITS));

  state_t              state, state_n;
  logic [OFF_BITS-1:0] beat;

  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_data;
  logic                hit;

  logic                arr_word_we;
  logic                arr_line_set;
  logic [OFF_BITS-1:0] arr_wr_offset;
  logic [31:0]         arr_wr_data;

  logic                start_write;
  logic                start_refill;

  assign hit = rd_valid && (rd_tag == tag);

  dcache_array #(
    .IDX_BITS (IDX_BITS),
    .OFF_BITS (OFF_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (index),
    .rd_offset (offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .word_we   (arr_word_we),
    .wr_offset (arr_wr_offset),
    .wr_data   (arr_wr_data),
    .line_set  (arr_line_set),
    .wr_tag    (tag)
  );

  // The request is live for the whole transaction, so it follows the state register
  // and drops the cycle after the accepting ack.
  assign mem.mem_req = (state != IDLE);

  always_comb begin
    state_n       = state;
    stall         = 1'b0;
    cpu_rdata     = 32'd0;
    arr_word_we   = 1'b0;
    arr_line_set  = 1'b0;
    arr_wr_offset = offset;
    arr_wr_data   = cpu_wdata;
    start_write   = 1'b0;
    start_refill  = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_we) begin
          stall       = 1'b1;
          start_write = 1'b1;
          state_n     = WRITE;
        end else if (cpu_re) begin
          if (hit) begin
            cpu_rdata = rd_data;
          end else begin
            stall        = 1'b1;
            start_refill = 1'b1;
            state_n      = REFILL;
          end
        end
      end

      REFILL: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          arr_word_we   = 1'b1;
          arr_wr_offset = beat;
          arr_wr_data   = mem.mem_rdata;
          // Line becomes valid only with its last word, so a partial line never hits.
          if (beat == OFF_BITS'(WPL - 1)) begin
            arr_line_set = 1'b1;
            state_n      = IDLE;
          end
        end
      end

      WRITE: begin
        // The core is released on the ack edge itself.
        stall = !mem.mem_ack;
        if (mem.mem_ack) begin
          state_n = IDLE;
          // Write-through: keep a resident copy coherent, never allocate on a miss.
          if (hit) begin
            arr_word_we = 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= 32'd0;
    end else begin
      state <= state_n;
      if (start_write) begin
        mem.mem_we    <= 1'b1;
        mem.mem_addr  <= word_addr;
        mem.mem_wdata <= cpu_wdata;
      end else if (start_refill) begin
        mem.mem_we   <= 1'b0;
        mem.mem_addr <= {tag, index, {OFF_BITS{1'b0}}};
        beat         <= '0;
      end else if (state == REFILL && mem.mem_ack) begin
        // Line base is aligned, so stepping the address walks the words in beat order.
        beat         <= beat + OFF_BITS'(1);
        mem.mem_addr <= mem.mem_addr + WA_W'(1);
      end
    end
  end

endmodule
